// File: rtl/fetch_seq.sv
// fetch_seq: instruction fetch sequencer (IDLE / FETCH / VALID).
// Keeps the PC, issues single-word instruction memory requests, holds the
// fetched word for decode and handles stalls, branches and flushes.
// Optional build macro: FETCH_TIMEOUT_EN adds a no-ack watchdog that raises a
// sticky fetch_err and parks the sequencer in IDLE until reset.
//
// Handshake: in FETCH, imem_req=1 and imem_addr (=pc) stay constant until the
// cycle imem_ack=1; that cycle is the transfer and imem_rdata is taken then.
// Decode sees instr while instr_valid=1 and consumes it on any cycle with
// stall=0 (or discards it on flush).
module fetch_seq #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          TIMEOUT      = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        stall,
    output logic [31:0] pc,
    output logic [31:0] inc_pc,
    input  logic [31:0] npc_result,
    input  logic        pc_src,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        fetch_err,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_VALID = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        pend_q, pend_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic        timeout_hit;
    logic        err_lock;
    logic        go;

`ifdef FETCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q;
    logic          err_q;

    // Watchdog: this cycle would be the TIMEOUT-th consecutive un-acked FETCH cycle
    always_comb begin
        timeout_hit = (state_q == S_FETCH) && !imem_ack && (cnt_q == CW'(TIMEOUT - 1));
    end

    // Count consecutive un-acked FETCH cycles; latch the sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q == S_FETCH && !imem_ack && !timeout_hit) cnt_q <= cnt_q + 1'b1;
            else                                                 cnt_q <= '0;
            if (timeout_hit) err_q <= 1'b1;
        end
    end

    assign err_lock  = err_q;
    assign fetch_err = err_q;
`else
    localparam int unused_timeout = TIMEOUT;
    assign timeout_hit = 1'b0;
    assign err_lock    = 1'b0;
    assign fetch_err   = 1'b0;
`endif

    // run is ignored once the watchdog has fired
    assign go = run && !err_lock;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (go) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) state_d = (flush || pend_q) ? S_FETCH : S_VALID;
                else if (timeout_hit) state_d = S_IDLE;
            end
            S_VALID: begin
                if (flush || !stall) state_d = go ? S_FETCH : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: decoded purely from state so reset drops imem_req at once
    always_comb begin
        imem_req    = (state_q == S_FETCH);
        instr_valid = (state_q == S_VALID);
    end

    assign state     = state_q;
    assign pc        = pc_q;
    assign imem_addr = pc_q;
    assign inc_pc    = pc_q + 32'd4;
    assign instr     = instr_q;

    // Datapath next values: PC redirect (flush > pc_src > inc_pc), instruction
    // capture and the pending-flush target held while a request is outstanding
    always_comb begin
        pc_d      = pc_q;
        instr_d   = instr_q;
        pend_d    = pend_q;
        pend_pc_d = pend_pc_q;
        case (state_q)
            S_IDLE: begin
                if (flush) pc_d = {flush_pc[31:2], 2'b00};
            end
            S_FETCH: begin
                if (imem_ack) begin
                    pend_d = 1'b0;
                    if (flush)       pc_d = {flush_pc[31:2], 2'b00};
                    else if (pend_q) pc_d = pend_pc_q;
                    else             instr_d = imem_rdata;
                end else if (timeout_hit) begin
                    pend_d = 1'b0;
                end else if (flush) begin
                    pend_d    = 1'b1;
                    pend_pc_d = {flush_pc[31:2], 2'b00};
                end
            end
            S_VALID: begin
                if (flush)       pc_d = {flush_pc[31:2], 2'b00};
                else if (!stall) pc_d = pc_src ? {npc_result[31:2], 2'b00} : inc_pc;
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= {RESET_VECTOR[31:2], 2'b00};
            instr_q   <= '0;
            pend_q    <= 1'b0;
            pend_pc_q <= '0;
        end else begin
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
        end
    end

endmodule
